// File: rtl/ahbreg_bank.sv
// ahbreg_bank: AHB-Lite slave with NUM_REGS 32-bit registers.
// Supports byte, halfword and word writes, read-only status slots, configurable
// wait states, and a two-cycle ERROR response for illegal accesses.
module ahbreg_bank #(
    parameter int unsigned          NUM_REGS    = 8,
    parameter logic [3:0]           BASE_NIBBLE = 4'h8,
    parameter int unsigned          WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0]  RO_MASK     = '0
) (
    input  logic                     hclk,
    input  logic                     hreset,
    input  logic [31:0]              haddr,
    input  logic [1:0]               htrans,
    input  logic                     hwrite,
    input  logic [2:0]               hsize,
    input  logic [2:0]               hburst,
    input  logic [31:0]              hwdata,
    input  logic                     hsel,
    input  logic                     hready_in,
    output logic                     hready,
    output logic [31:0]              hrdata,
    output logic [1:0]               hresp,
    input  logic [32*NUM_REGS-1:0]   status_in,
    output logic [32*NUM_REGS-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int unsigned AW      = $clog2(NUM_REGS);
    localparam logic [1:0]  WS_LOAD = 2'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

    state_t                r_state;
    logic [1:0]            r_cnt;
    logic                  r_hready;
    logic [1:0]            r_hresp;
    logic                  r_dp_valid;
    logic                  r_dp_write;
    logic [AW-1:0]         r_idx;
    logic [3:0]            r_lanes;
    logic [31:0]           r_regs [NUM_REGS];
    logic [NUM_REGS-1:0]   r_wr_pulse;

    logic                  w_accept;
    logic                  w_err;
    logic [AW-1:0]         w_idx;
    logic [3:0]            w_lanes;
    logic                  w_commit;
    logic [31:0]           w_rword;
    logic                  w_unused_ok;

    // Burst type and the SEQ/NONSEQ distinction carry no meaning here.
    assign w_unused_ok = ^{hburst, htrans[0]};

    assign w_accept = hsel & hready_in & htrans[1] & r_hready;
    assign w_idx    = haddr[AW+1:2];
    assign w_commit = r_dp_valid & r_dp_write & r_hready;

    assign hready   = r_hready;
    assign hresp    = r_hresp;
    assign wr_pulse = r_wr_pulse;

    // Address-phase decode: flag any access that must get an ERROR response.
    always_comb begin
        w_err = 1'b0;
        if (haddr[31:28] != BASE_NIBBLE)                w_err = 1'b1;
        if ((haddr[27:0] >> (AW + 2)) != 28'd0)         w_err = 1'b1;
        if (hsize > 3'd2)                               w_err = 1'b1;
        if (hsize == 3'd1 && haddr[0])                  w_err = 1'b1;
        if (hsize == 3'd2 && haddr[1:0] != 2'b00)       w_err = 1'b1;
        if (hwrite && RO_MASK[w_idx])                   w_err = 1'b1;
    end

    // Byte-lane enables derived from transfer size and low address bits.
    always_comb begin
        case (hsize)
            3'd0:    w_lanes = 4'b0001 << haddr[1:0];
            3'd1:    w_lanes = haddr[1] ? 4'b1100 : 4'b0011;
            default: w_lanes = 4'b1111;
        endcase
    end

    // Response FSM: wait-state insertion and the two-cycle ERROR sequence.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 2'd0;
            r_hready <= 1'b1;
            r_hresp  <= 2'b00;
        end else begin
            case (r_state)
                ST_IDLE, ST_ERR2: begin
                    if (w_accept && w_err) begin
                        r_state  <= ST_ERR1;
                        r_hready <= 1'b0;
                        r_hresp  <= 2'b01;
                    end else if (w_accept && WAIT_STATES != 0) begin
                        r_state  <= ST_WAIT;
                        r_cnt    <= WS_LOAD;
                        r_hready <= 1'b0;
                        r_hresp  <= 2'b00;
                    end else begin
                        r_state  <= ST_IDLE;
                        r_hready <= 1'b1;
                        r_hresp  <= 2'b00;
                    end
                end
                ST_WAIT: begin
                    r_hresp <= 2'b00;
                    if (r_cnt == 2'd1) begin
                        r_state  <= ST_IDLE;
                        r_cnt    <= 2'd0;
                        r_hready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_ERR1: begin
                    r_state  <= ST_ERR2;
                    r_hready <= 1'b1;
                    r_hresp  <= 2'b01;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_cnt    <= 2'd0;
                    r_hready <= 1'b1;
                    r_hresp  <= 2'b00;
                end
            endcase
        end
    end

    // Capture address-phase attributes; held while the data phase is stalled.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_dp_valid <= 1'b0;
            r_dp_write <= 1'b0;
            r_idx      <= '0;
            r_lanes    <= '0;
        end else if (r_hready) begin
            r_dp_valid <= w_accept & ~w_err;
            r_dp_write <= hwrite;
            r_idx      <= w_idx;
            r_lanes    <= w_lanes;
        end
    end

    // Register file: commit enabled byte lanes when an OKAY write completes.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_lanes[b]) begin
                    r_regs[r_idx][8*b +: 8] <= hwdata[8*b +: 8];
                end
            end
        end
    end

    // One-cycle write strobe for the register just written.
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_wr_pulse <= '0;
        end else begin
            r_wr_pulse <= '0;
            if (w_commit) begin
                r_wr_pulse[r_idx] <= 1'b1;
            end
        end
    end

    // Read mux: status word for read-only slots, stored word otherwise.
    always_comb begin
        w_rword = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (r_idx == AW'(i)) begin
                w_rword = RO_MASK[i] ? status_in[32*i +: 32] : r_regs[i];
            end
        end
        hrdata = (r_dp_valid && !r_dp_write) ? w_rword : '0;
    end

    // Flattened register contents; read-only slots present zero.
    always_comb begin
        reg_out = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            reg_out[32*i +: 32] = RO_MASK[i] ? 32'h0 : r_regs[i];
        end
    end

endmodule

// File: tb/tb_ahbreg_bank.sv
// Testbench for ahbreg_bank: instance 0 has no wait states and register 2
// read-only; instance 1 has two wait states. A monitor pops expected responses.
module tb_ahbreg_bank;

    logic               hclk;
    logic               hreset;
    logic               hsel      [2];
    logic [31:0]        haddr     [2];
    logic [1:0]         htrans    [2];
    logic               hwrite    [2];
    logic [2:0]         hsize     [2];
    logic [2:0]         hburst    [2];
    logic [31:0]        hwdata    [2];
    logic               hready    [2];
    logic [31:0]        hrdata    [2];
    logic [1:0]         hresp     [2];
    logic [255:0]       status_in [2];
    logic [255:0]       reg_out   [2];
    logic [7:0]         wr_pulse  [2];

    ahbreg_bank #(.NUM_REGS(8), .BASE_NIBBLE(4'h8), .WAIT_STATES(0), .RO_MASK(8'h04)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .haddr(haddr[0]), .htrans(htrans[0]),
        .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
        .hsel(hsel[0]), .hready_in(hready[0]), .hready(hready[0]), .hrdata(hrdata[0]),
        .hresp(hresp[0]), .status_in(status_in[0]), .reg_out(reg_out[0]),
        .wr_pulse(wr_pulse[0])
    );

    ahbreg_bank #(.NUM_REGS(8), .BASE_NIBBLE(4'h8), .WAIT_STATES(2), .RO_MASK(8'h00)) u_ws2 (
        .hclk(hclk), .hreset(hreset), .haddr(haddr[1]), .htrans(htrans[1]),
        .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
        .hsel(hsel[1]), .hready_in(hready[1]), .hready(hready[1]), .hrdata(hrdata[1]),
        .hresp(hresp[1]), .status_in(status_in[1]), .reg_out(reg_out[1]),
        .wr_pulse(wr_pulse[1])
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // Scoreboard of expected bus responses, one entry per accepted transfer.
    int          sb_inst [$];
    logic [31:0] sb_rd   [$];
    logic [1:0]  sb_rsp  [$];
    int          sb_wait [$];
    // Direct observations sampled by the driver, compared by the monitor.
    string       dq_name [$];
    logic [31:0] dq_act  [$];
    logic [31:0] dq_exp  [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        dq_name.push_back(name);
        dq_act.push_back(act);
        dq_exp.push_back(exp);
    endtask

    function automatic logic [31:0] word(input int k, input int i);
        logic [255:0] v;
        v = reg_out[k];
        return v[32*i +: 32];
    endfunction

    // Monitor: compares each completed data phase and all queued observations.
    initial begin
        bit pend [2];
        int waits [2];
        int tnum;
        pend[0] = 1'b0; pend[1] = 1'b0;
        waits[0] = 0;   waits[1] = 0;
        tnum = 0;
        forever begin
            @(negedge hclk);
            while (dq_exp.size() > 0) begin
                string nm;
                logic [31:0] a, e;
                nm = dq_name.pop_front();
                a  = dq_act.pop_front();
                e  = dq_exp.pop_front();
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got 0x%08h expected 0x%08h", nm, a, e);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (hreset) begin
                    pend[k] = 1'b0;
                end else begin
                    if (pend[k]) begin
                        if (!hready[k]) begin
                            waits[k]++;
                        end else begin
                            pend[k] = 1'b0;
                            if (sb_rd.size() == 0) begin
                                n_checks++;
                                n_fail++;
                                $display("FAIL unexpected_resp inst%0d: got a response, expected none", k);
                            end else begin
                                int ei, ew;
                                logic [31:0] erd;
                                logic [1:0] ers;
                                ei  = sb_inst.pop_front();
                                erd = sb_rd.pop_front();
                                ers = sb_rsp.pop_front();
                                ew  = sb_wait.pop_front();
                                tnum++;
                                n_checks++;
                                if (ei != k) begin
                                    n_fail++;
                                    $display("FAIL xfer%0d_inst: got %0d expected %0d", tnum, k, ei);
                                end
                                n_checks++;
                                if (hrdata[k] !== erd) begin
                                    n_fail++;
                                    $display("FAIL xfer%0d_hrdata: got 0x%08h expected 0x%08h", tnum, hrdata[k], erd);
                                end
                                n_checks++;
                                if (hresp[k] !== ers) begin
                                    n_fail++;
                                    $display("FAIL xfer%0d_hresp: got %0b expected %0b", tnum, hresp[k], ers);
                                end
                                n_checks++;
                                if (waits[k] != ew) begin
                                    n_fail++;
                                    $display("FAIL xfer%0d_waits: got %0d expected %0d", tnum, waits[k], ew);
                                end
                            end
                        end
                    end
                    if (hsel[k] && htrans[k][1] && hready[k]) begin
                        pend[k] = 1'b1;
                        waits[k] = 0;
                    end
                end
            end
        end
    end

    task automatic expect_resp(input int k, input logic [31:0] erd, input logic [1:0] ersp, input int ew);
        sb_inst.push_back(k);
        sb_rd.push_back(erd);
        sb_rsp.push_back(ersp);
        sb_wait.push_back(ew);
    endtask

    // Single non-pipelined transfer; returns one cycle after the completing edge.
    task automatic xfer(input int k, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input logic [31:0] erd, input logic [1:0] ersp,
                        input int ew);
        int n;
        expect_resp(k, erd, ersp, ew);
        haddr[k]  = a;
        hwrite[k] = w;
        hsize[k]  = sz;
        hsel[k]   = 1'b1;
        htrans[k] = 2'b10;
        @(posedge hclk); #1;
        hsel[k]   = 1'b0;
        htrans[k] = 2'b00;
        hwdata[k] = wd;
        n = 0;
        forever begin
            @(negedge hclk);
            if (hready[k]) break;
            n++;
            if (n > 20) begin
                chk("timeout_hready", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge hclk); #1;
        hwdata[k] = '0;
    endtask

    task automatic idle_cycle();
        @(posedge hclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        hreset = 1'b1;
        for (int k = 0; k < 2; k++) begin
            hsel[k] = 1'b0; haddr[k] = '0; htrans[k] = '0; hwrite[k] = 1'b0;
            hsize[k] = '0; hburst[k] = '0; hwdata[k] = '0;
        end
        status_in[0] = '0;
        status_in[0][63:32] = 32'hFFFF0000;
        status_in[0][95:64] = 32'h12345678;
        status_in[1] = '1;
        repeat (3) @(posedge hclk);
        #1 hreset = 1'b0;
        idle_cycle();

        // Reset state on both instances
        for (int k = 0; k < 2; k++) begin
            chk("rst_hready", 32'(hready[k]), 32'd1);
            chk("rst_hresp",  32'(hresp[k]),  32'd0);
            chk("rst_hrdata", hrdata[k],      32'd0);
            chk("rst_regout_or", 32'(|reg_out[k]), 32'd0);
            chk("rst_wr_pulse", 32'(wr_pulse[k]), 32'd0);
        end

        // Word write then read, zero wait states
        xfer(0, 32'h8000_0004, 1'b1, 3'd2, 32'hDEADBEEF, 32'h0, 2'b00, 0);
        chk("wr_pulse_reg1", 32'(wr_pulse[0]), 32'h02);
        chk("reg_out_w1", word(0, 1), 32'hDEADBEEF);
        idle_cycle();
        chk("wr_pulse_clear", 32'(wr_pulse[0]), 32'h00);
        xfer(0, 32'h8000_0004, 1'b0, 3'd2, 32'h0, 32'hDEADBEEF, 2'b00, 0);

        // Byte and halfword lane writes into reg0
        xfer(0, 32'h8000_0000, 1'b1, 3'd2, 32'h11223344, 32'h0, 2'b00, 0);
        xfer(0, 32'h8000_0002, 1'b1, 3'd0, 32'h00AA0000, 32'h0, 2'b00, 0);
        chk("byte_write_reg0", word(0, 0), 32'h11AA3344);
        xfer(0, 32'h8000_0000, 1'b0, 3'd2, 32'h0, 32'h11AA3344, 2'b00, 0);
        xfer(0, 32'h8000_0002, 1'b1, 3'd1, 32'h55660000, 32'h0, 2'b00, 0);
        chk("half_write_reg0", word(0, 0), 32'h55663344);
        xfer(0, 32'h8000_0001, 1'b0, 3'd0, 32'h0, 32'h55663344, 2'b00, 0);

        // Illegal accesses: two-cycle ERROR, no register change
        xfer(0, 32'h8000_0001, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0, 2'b01, 1);
        xfer(0, 32'h8000_0100, 1'b0, 3'd2, 32'h0,        32'h0, 2'b01, 1);
        xfer(0, 32'h9000_0000, 1'b1, 3'd2, 32'hFFFFFFFF, 32'h0, 2'b01, 1);
        xfer(0, 32'h8000_0000, 1'b1, 3'd3, 32'hFFFFFFFF, 32'h0, 2'b01, 1);
        xfer(0, 32'h8000_0005, 1'b1, 3'd1, 32'hFFFFFFFF, 32'h0, 2'b01, 1);
        chk("err_reg0_kept", word(0, 0), 32'h55663344);
        chk("err_reg1_kept", word(0, 1), 32'hDEADBEEF);
        chk("err_no_pulse", 32'(wr_pulse[0]), 32'h00);

        // Read-only status register
        xfer(0, 32'h8000_0008, 1'b0, 3'd2, 32'h0, 32'h12345678, 2'b00, 0);
        xfer(0, 32'h8000_0008, 1'b1, 3'd2, 32'hCAFECAFE, 32'h0, 2'b01, 1);
        chk("ro_no_pulse", 32'(wr_pulse[0]), 32'h00);
        chk("ro_regout_zero", word(0, 2), 32'h0);

        // Pipelined write followed by read of the same register
        expect_resp(0, 32'h0, 2'b00, 0);
        expect_resp(0, 32'hCAFEF00D, 2'b00, 0);
        haddr[0] = 32'h8000_000C; hwrite[0] = 1'b1; hsize[0] = 3'd2;
        hsel[0] = 1'b1; htrans[0] = 2'b10;
        @(posedge hclk); #1;
        hwdata[0] = 32'hCAFEF00D; hwrite[0] = 1'b0;
        @(posedge hclk); #1;
        hsel[0] = 1'b0; htrans[0] = 2'b00; hwdata[0] = '0;
        chk("b2b_wr_pulse", 32'(wr_pulse[0]), 32'h08);
        idle_cycle();
        xfer(0, 32'h8000_0014, 1'b0, 3'd2, 32'h0, 32'h0, 2'b00, 0);

        // Two wait states
        xfer(1, 32'h8000_000C, 1'b1, 3'd2, 32'hA5A5A5A5, 32'h0, 2'b00, 2);
        chk("ws2_wr_pulse", 32'(wr_pulse[1]), 32'h08);
        xfer(1, 32'h8000_000C, 1'b0, 3'd2, 32'h0, 32'hA5A5A5A5, 2'b00, 2);
        xfer(1, 32'h9000_0000, 1'b0, 3'd2, 32'h0, 32'h0, 2'b01, 1);

        // Reset during a wait-stated write
        haddr[1] = 32'h8000_0010; hwrite[1] = 1'b1; hsize[1] = 3'd2;
        hsel[1] = 1'b1; htrans[1] = 2'b10;
        @(posedge hclk); #1;
        hsel[1] = 1'b0; htrans[1] = 2'b00; hwdata[1] = 32'h0BADF00D;
        #2 hreset = 1'b1;
        @(posedge hclk); #1;
        hreset = 1'b0; hwdata[1] = '0;
        idle_cycle();
        chk("rst_mid_hready", 32'(hready[1]), 32'd1);
        chk("rst_mid_reg4", word(1, 4), 32'h0);
        chk("rst_mid_reg3", word(1, 3), 32'h0);
        chk("rst_mid_pulse", 32'(wr_pulse[1]), 32'h00);
        xfer(1, 32'h8000_0010, 1'b1, 3'd2, 32'h13579BDF, 32'h0, 2'b00, 2);
        xfer(1, 32'h8000_0010, 1'b0, 3'd2, 32'h0, 32'h13579BDF, 2'b00, 2);
        chk("post_rst_reg4", word(1, 4), 32'h13579BDF);

        idle_cycle();
        chk("sb_drained", 32'(sb_rd.size()), 32'd0);
        repeat (3) @(posedge hclk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
